// File: rtl/wb_buffer.sv
// wb_buffer: FIFO of evicted dirty lines drained to memory as single-word write bursts, with address lookup
module wb_buffer #(
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 2,
  localparam int LINE_LEN      = WORDS_PER_LINE * WORD_WIDTH,
  localparam int LADDR_W       = ADDR_WIDTH - $clog2(WORDS_PER_LINE) - $clog2(WORD_WIDTH / 8)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  evict_valid_i,
  output logic                  evict_ready_o,
  input  logic [LADDR_W-1:0]    evict_laddr_i,
  input  logic [LINE_LEN-1:0]   evict_data_i,
  output logic                  mem_wr_valid_o,
  input  logic                  mem_wr_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WORD_WIDTH-1:0] mem_wr_data_o,
  output logic                  mem_last_o,
  input  logic [LADDR_W-1:0]    lookup_laddr_i,
  output logic                  lookup_hit_o,
  output logic                  empty_o,
  output logic                  full_o
);
  localparam int WIDX_W = $clog2(WORDS_PER_LINE);
  localparam int BOFF_W = $clog2(WORD_WIDTH / 8);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [WIDX_W-1:0] LAST_W  = WIDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q;
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WIDX_W-1:0]   widx_q;
  logic [LADDR_W-1:0]  laddr_mem [DEPTH];
  logic [LINE_LEN-1:0] data_mem [DEPTH];
  logic                push, beat, last_beat;
  logic [PTR_W-1:0]    off;

  assign evict_ready_o  = rst_ni && (count_q < DEPTH_C);
  assign push           = evict_valid_i && evict_ready_o;
  assign mem_wr_valid_o = state_q == BURST;
  assign mem_last_o     = mem_wr_valid_o && (widx_q == LAST_W);
  assign beat           = mem_wr_valid_o && mem_wr_ready_i;
  assign last_beat      = beat && mem_last_o;
  assign count_d        = count_q + CNT_W'(push) - CNT_W'(last_beat);
  assign mem_addr_o     = mem_wr_valid_o ? {laddr_mem[rd_ptr_q], widx_q, {BOFF_W{1'b0}}} : '0;
  assign mem_wr_data_o  = mem_wr_valid_o ? data_mem[rd_ptr_q][widx_q*WORD_WIDTH +: WORD_WIDTH] : '0;
  assign full_o         = count_q == DEPTH_C;
  assign empty_o        = (count_q == '0) && (state_q == IDLE);

  // An entry is live when its distance from rd_ptr is below count, so the head stays hit-visible mid-burst
  always_comb begin
    lookup_hit_o = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      lookup_hit_o = lookup_hit_o | ((CNT_W'(off) < count_q) && (laddr_mem[i] == lookup_laddr_i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      laddr_mem[wr_ptr_q] <= evict_laddr_i;
      data_mem[wr_ptr_q]  <= evict_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      widx_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (state_q == IDLE) begin
        if (count_q != '0) begin
          state_q <= BURST;
          widx_q  <= '0;
        end
      end else if (beat) begin
        widx_q <= widx_q + WIDX_W'(1);
        if (mem_last_o) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
          if (count_d == '0) state_q <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_buffer.sv
// tb_wb_buffer: directed and randomized checks of wb_buffer against a queue-based line model
module tb_wb_buffer;
  localparam int WW = 32, WPL = 4, AW = 32, D = 2, LW = 28, LL = 128;

  logic          clk_i = 0, rst_ni = 0, evict_valid_i = 0, mem_wr_ready_i = 0;
  logic [LW-1:0] evict_laddr_i = '0, lookup_laddr_i = '0;
  logic [LL-1:0] evict_data_i = '0;
  logic          evict_ready_o, mem_wr_valid_o, mem_last_o, lookup_hit_o, empty_o, full_o;
  logic [AW-1:0] mem_addr_o;
  logic [WW-1:0] mem_wr_data_o;

  int checks = 0, errors = 0;

  wb_buffer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .evict_valid_i(evict_valid_i), .evict_ready_o(evict_ready_o),
    .evict_laddr_i(evict_laddr_i), .evict_data_i(evict_data_i),
    .mem_wr_valid_o(mem_wr_valid_o), .mem_wr_ready_i(mem_wr_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o), .mem_last_o(mem_last_o),
    .lookup_laddr_i(lookup_laddr_i), .lookup_hit_o(lookup_hit_o),
    .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a queue of pending lines, the index of the next word of the head, and whether a burst is running
  logic [LW-1:0] qa[$];
  logic [LL-1:0] qd[$];
  int            widx = 0, pre;
  bit            busy = 0, mpush, hit;
  logic [LL-1:0] ln;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      qa.delete(); qd.delete(); widx = 0; busy = 0;
    end else begin
      pre = qa.size();
      mpush = evict_valid_i && pre < D;
      if (busy && mem_wr_ready_i) begin
        if (widx == WPL - 1) begin
          qa.pop_front(); qd.pop_front(); widx = 0;
        end else widx++;
      end
      if (mpush) begin
        qa.push_back(evict_laddr_i); qd.push_back(evict_data_i);
      end
      busy = busy ? (qa.size() > 0) : (pre > 0);
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      hit = 0;
      foreach (qa[i]) if (qa[i] == lookup_laddr_i) hit = 1;
      chk("evict_ready", evict_ready_o, qa.size() < D);
      chk("full", full_o, qa.size() == D);
      chk("empty", empty_o, qa.size() == 0);
      chk("lookup_hit", lookup_hit_o, hit);
      chk("wr_valid", mem_wr_valid_o, busy);
      if (busy) begin
        ln = qd[0];
        chk("addr", mem_addr_o, {qa[0], 2'(widx), 2'b00});
        chk("data", mem_wr_data_o, ln[widx*WW +: WW]);
        chk("last", mem_last_o, widx == WPL - 1);
      end
    end
  end

  int            dut_beats = 0;
  logic [LW-1:0] dlog[$];
  always @(posedge clk_i) begin
    if (rst_ni && mem_wr_valid_o && mem_wr_ready_i) begin
      dut_beats++;
      if (mem_last_o) dlog.push_back(mem_addr_o[31:4]);
    end
  end

  task step; @(posedge clk_i); #1; endtask

  task automatic push(input logic [LW-1:0] a, input logic [LL-1:0] d);
    evict_laddr_i = a; evict_data_i = d; evict_valid_i = 1;
    chk("push_ready", evict_ready_o, 1);
    step;
    evict_valid_i = 0;
  endtask

  task automatic wait_valid;
    int n = 0;
    while (!mem_wr_valid_o && n < 20) begin step; n++; end
    chk("wait_valid", mem_wr_valid_o, 1);
  endtask

  localparam logic [LL-1:0] L1 = 128'h000000D3_000000C2_000000B1_000000A0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step;
    chk("rst_valid", mem_wr_valid_o, 0);
    chk("rst_ready", evict_ready_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_hit", lookup_hit_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", mem_wr_data_o, 0);
    chk("rst_last", mem_last_o, 0);
    rst_ni = 1;
    step;
    // single line, ready held high
    mem_wr_ready_i = 1; dut_beats = 0;
    push(28'h0000123, L1);
    wait_valid;
    for (int b = 0; b < 4; b++) begin
      chk("t1_addr", mem_addr_o, 32'h1230 + 4 * b);
      chk("t1_data", mem_wr_data_o, 32'hA0 + 32'h11 * b);
      chk("t1_last", mem_last_o, b == 3);
      step;
    end
    chk("t1_empty_after", empty_o, 1);
    chk("t1_beats", dut_beats, 4);
    // backpressure on beat 2
    dut_beats = 0;
    push(28'h0000123, L1);
    wait_valid;
    step; step;
    mem_wr_ready_i = 0;
    repeat (3) begin
      chk("t2_hold_addr", mem_addr_o, 32'h1238);
      chk("t2_hold_data", mem_wr_data_o, 32'hC2);
      chk("t2_hold_last", mem_last_o, 0);
      step;
    end
    mem_wr_ready_i = 1;
    step;
    chk("t2_beat3_addr", mem_addr_o, 32'h123C);
    chk("t2_beat3_last", mem_last_o, 1);
    step;
    chk("t2_done", mem_wr_valid_o, 0);
    chk("t2_beats", dut_beats, 4);
    // fill to full, reject a third line, then drain with no gap
    mem_wr_ready_i = 0; dlog.delete();
    push(28'h10, {4{32'h1111_0000}});
    push(28'h20, {4{32'h2222_0000}});
    chk("t3_full", full_o, 1);
    chk("t3_not_ready", evict_ready_o, 0);
    evict_laddr_i = 28'h30; evict_valid_i = 1;
    step; step;
    chk("t3_still_full", full_o, 1);
    evict_valid_i = 0;
    mem_wr_ready_i = 1;
    for (int k = 0; k < 8; k++) begin
      chk("t3_no_gap", mem_wr_valid_o, 1);
      chk("t3_addr", mem_addr_o, {(k < 4) ? 28'h10 : 28'h20, 2'(k % 4), 2'b00});
      step;
    end
    chk("t3_drained", mem_wr_valid_o, 0);
    chk("t3_lines", dlog.size(), 2);
    // third push held across the final beat of the head line
    mem_wr_ready_i = 0; dlog.delete();
    push(28'h40, {4{32'h4444_0000}});
    push(28'h50, {4{32'h5555_0000}});
    evict_laddr_i = 28'h60; evict_data_i = {4{32'h6666_0000}}; evict_valid_i = 1;
    mem_wr_ready_i = 1;
    repeat (3) step;
    chk("t4_final_beat", mem_last_o, 1);
    chk("t4_blocked", evict_ready_o, 0);
    step;
    chk("t4_ready_rises", evict_ready_o, 1);
    chk("t4_not_full", full_o, 0);
    step;
    chk("t4_refull", full_o, 1);
    evict_valid_i = 0;
    repeat (10) step;
    chk("t4_lines", dlog.size(), 3);
    chk("t4_order0", dlog[0], 28'h40);
    chk("t4_order1", dlog[1], 28'h50);
    chk("t4_order2", dlog[2], 28'h60);
    // lookup visibility
    mem_wr_ready_i = 0; lookup_laddr_i = 28'h456;
    evict_laddr_i = 28'h456; evict_data_i = L1; evict_valid_i = 1;
    #1 chk("t5_not_yet", lookup_hit_o, 0);
    step;
    evict_valid_i = 0;
    chk("t5_visible", lookup_hit_o, 1);
    lookup_laddr_i = 28'h457;
    #1 chk("t5_miss", lookup_hit_o, 0);
    lookup_laddr_i = 28'h456;
    #1 chk("t5_hit_again", lookup_hit_o, 1);
    mem_wr_ready_i = 1;
    wait_valid;
    for (int b = 0; b < 4; b++) begin
      chk("t5_hit_burst", lookup_hit_o, 1);
      step;
    end
    chk("t5_gone", lookup_hit_o, 0);
    // asynchronous reset mid-burst
    mem_wr_ready_i = 0;
    push(28'h70, {4{32'h7777_0000}});
    push(28'h80, {4{32'h8888_0000}});
    wait_valid;
    mem_wr_ready_i = 1;
    step; step;
    chk("t6_beat2", mem_addr_o, {28'h70, 2'd2, 2'b00});
    mem_wr_ready_i = 0;
    #2 rst_ni = 0;
    #1;
    chk("t6_valid_drop", mem_wr_valid_o, 0);
    chk("t6_empty", empty_o, 1);
    chk("t6_full", full_o, 0);
    step; step;
    rst_ni = 1; dut_beats = 0; mem_wr_ready_i = 1;
    repeat (10) step;
    chk("t6_no_replay", dut_beats, 0);
    chk("t6_empty_after", empty_o, 1);
    // randomized traffic with a small address pool for duplicates and lookup hits
    for (int c = 0; c < 1500; c++) begin
      evict_valid_i  = 1'($urandom_range(0, 1));
      evict_laddr_i  = 28'h100 + 28'($urandom_range(0, 3));
      evict_data_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_wr_ready_i = $urandom_range(0, 3) != 0;
      lookup_laddr_i = 28'h100 + 28'($urandom_range(0, 4));
      step;
    end
    evict_valid_i = 0; mem_wr_ready_i = 1;
    repeat (30) step;
    chk("rand_drained", empty_o, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
